// File: rtl/pll_calib_pkg.sv
// pll_calib_pkg: state encoding, table entry layout and small helpers shared by the
// PLL calibration sequencer and its lock-window finder.
package pll_calib_pkg;

  localparam int ICP_W   = 6;
  localparam int LPF_W   = 3;
  localparam int ENTRY_W = ICP_W + LPF_W;
  localparam int ICP_LSB = 0;
  localparam int LPF_LSB = ICP_W;
  localparam int IDX_W   = 4;
  localparam int LEN_W   = 5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_APPLY  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_EVAL   = 3'd4,
    ST_FAPPLY = 3'd5,
    ST_FWAIT  = 3'd6,
    ST_DONE   = 3'd7
  } pll_state_e;

  // One table entry, packed as {LPFRES, ICPSEL} with ICPSEL in the LSBs.
  typedef struct packed {
    logic [LPF_W-1:0] lpf;
    logic [ICP_W-1:0] icp;
  } entry_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Centre of a lock window; an even-length run rounds towards its start.
  function automatic logic [IDX_W-1:0] window_mid(input logic [IDX_W-1:0] start,
                                                  input logic [LEN_W-1:0] len);
    logic [LEN_W-1:0] half;
    half = (len - LEN_W'(1)) >> 1;
    return start + IDX_W'(half);
  endfunction

endpackage

// File: rtl/pll_calib_window.sv
// pll_calib_window: serial longest-run-of-ones finder; the first (lowest-start) run wins ties.
module pll_calib_window
  import pll_calib_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             valid,
  input  logic             bit_in,
  output logic [IDX_W-1:0] start,
  output logic [LEN_W-1:0] len
);

  logic [IDX_W-1:0] pos_q, pos_d;
  logic [IDX_W-1:0] cur_start_q, cur_start_d;
  logic [LEN_W-1:0] cur_len_q, cur_len_d;
  logic [IDX_W-1:0] best_start_q, best_start_d;
  logic [LEN_W-1:0] best_len_q, best_len_d;
  logic [LEN_W-1:0] run_len_s;

  // Run tracking: best only moves on a strictly longer run.
  always_comb begin
    pos_d        = pos_q;
    cur_start_d  = cur_start_q;
    cur_len_d    = cur_len_q;
    best_start_d = best_start_q;
    best_len_d   = best_len_q;
    run_len_s    = cur_len_q + LEN_W'(1);
    if (clear) begin
      pos_d        = '0;
      cur_start_d  = '0;
      cur_len_d    = '0;
      best_start_d = '0;
      best_len_d   = '0;
    end else if (valid) begin
      pos_d = pos_q + IDX_W'(1);
      if (bit_in) begin
        cur_len_d = run_len_s;
        if (cur_len_q == '0) begin
          cur_start_d = pos_q;
        end else begin
          cur_start_d = cur_start_q;
        end
        if (run_len_s > best_len_q) begin
          best_len_d   = run_len_s;
          best_start_d = (cur_len_q == '0) ? pos_q : cur_start_q;
        end else begin
          best_len_d   = best_len_q;
        end
      end else begin
        cur_len_d = '0;
      end
    end else begin
      pos_d = pos_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pos_q        <= '0;
      cur_start_q  <= '0;
      cur_len_q    <= '0;
      best_start_q <= '0;
      best_len_q   <= '0;
    end else begin
      pos_q        <= pos_d;
      cur_start_q  <= cur_start_d;
      cur_len_q    <= cur_len_d;
      best_start_q <= best_start_d;
      best_len_q   <= best_len_d;
    end
  end

  assign start = best_start_q;
  assign len   = best_len_q;

endmodule

// File: rtl/pll_calib_seq.sv
// pll_calib_seq: sweeps the ICP/LPF table, records per-step lock and applies the centre of the
// longest lock window. Define PLL_CALIB_RELOCK_EN to re-run the sweep after sustained lock loss.
module pll_calib_seq
  import pll_calib_pkg::*;
#(
  parameter int                         CLK_PERIOD   = 50,
  parameter int                         WAIT_TIME    = 2000000,
  parameter int                         RST_CYCLES   = 4,
  parameter int                         STEPS        = 8,
  parameter logic [STEPS*ENTRY_W-1:0]   STEP_TABLE   = '0,
  parameter int                         DEFAULT_STEP = 0,
  parameter int                         LOSS_CYCLES  = 16
) (
  input  logic             CLKIN,
  input  logic             I_RSTN,
  input  logic             PLLLOCK,
  output logic             O_RST,
  output logic [ICP_W-1:0] ICPSEL,
  output logic [LPF_W-1:0] LPFRES,
  output logic             O_LOCK,
  output logic             O_BUSY,
  output logic             O_FAIL,
  output logic [STEPS-1:0] O_LOCKMAP,
  output logic [IDX_W-1:0] O_SEL
);

  localparam int WAIT_CNT = (WAIT_TIME + CLK_PERIOD - 1) / CLK_PERIOD;
  localparam int CNT_MAX  = max_int(max_int(WAIT_CNT, RST_CYCLES), max_int(STEPS, LOSS_CYCLES));
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  localparam logic [2:0] IDLE   = ST_IDLE;
  localparam logic [2:0] APPLY  = ST_APPLY;
  localparam logic [2:0] WAIT   = ST_WAIT;
  localparam logic [2:0] SAMPLE = ST_SAMPLE;
  localparam logic [2:0] EVAL   = ST_EVAL;
  localparam logic [2:0] FAPPLY = ST_FAPPLY;
  localparam logic [2:0] FWAIT  = ST_FWAIT;
  localparam logic [2:0] DONE   = ST_DONE;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [1:0]       sync_q, sync_d;
  logic [STEPS-1:0] lockmap_q, lockmap_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic             fail_q, fail_d;
  logic [ICP_W-1:0] icp_q, icp_d;
  logic [LPF_W-1:0] lpf_q, lpf_d;
  logic             o_rst_q, o_rst_d;
  logic             o_lock_q, o_lock_d;
  logic             o_busy_q, o_busy_d;

  logic             lock_s;
  logic             load_s;
  logic [IDX_W-1:0] load_idx_s;
  entry_t           entry_s;
  logic             win_clear_s;
  logic             win_valid_s;
  logic             scan_bit_s;
  logic [IDX_W-1:0] win_start_s;
  logic [LEN_W-1:0] win_len_s;

  function automatic entry_t entry_at(input logic [IDX_W-1:0] idx);
    return entry_t'(ENTRY_W'(STEP_TABLE >> (int'(idx) * ENTRY_W)));
  endfunction

  assign lock_s     = sync_q[1];
  assign scan_bit_s = |(lockmap_q & (STEPS'(1'b1) << cnt_q));

  pll_calib_window u_window (
    .clk    (CLKIN),
    .rst_n  (I_RSTN),
    .clear  (win_clear_s),
    .valid  (win_valid_s),
    .bit_in (scan_bit_s),
    .start  (win_start_s),
    .len    (win_len_s)
  );

  // Sequencer next-state; the shared counter times reset pulses, settle waits, the scan and lock loss.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    lockmap_d   = lockmap_q;
    sel_d       = sel_q;
    fail_d      = fail_q;
    load_s      = 1'b0;
    load_idx_s  = idx_q;
    win_clear_s = 1'b0;
    win_valid_s = 1'b0;
    sync_d      = {sync_q[0], PLLLOCK};
    case (state_q)
      IDLE: begin
        state_d    = APPLY;
        idx_d      = '0;
        cnt_d      = '0;
        load_s     = 1'b1;
        load_idx_s = '0;
      end
      APPLY, FAPPLY: begin
        if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = (state_q == APPLY) ? WAIT : FWAIT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT, FWAIT: begin
        if (cnt_q == CNT_W'(WAIT_CNT - 1)) begin
          cnt_d   = '0;
          state_d = (state_q == WAIT) ? SAMPLE : DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SAMPLE: begin
        lockmap_d = (lockmap_q & ~(STEPS'(1'b1) << idx_q)) | (STEPS'(lock_s) << idx_q);
        cnt_d     = '0;
        if (idx_q < IDX_W'(STEPS - 1)) begin
          idx_d      = idx_q + IDX_W'(1);
          state_d    = APPLY;
          load_s     = 1'b1;
          load_idx_s = idx_q + IDX_W'(1);
        end else begin
          state_d     = EVAL;
          win_clear_s = 1'b1;
        end
      end
      EVAL: begin
        if (cnt_q < CNT_W'(STEPS)) begin
          win_valid_s = 1'b1;
          cnt_d       = cnt_q + CNT_W'(1);
        end else begin
          cnt_d   = '0;
          state_d = FAPPLY;
          load_s  = 1'b1;
          if (win_len_s == '0) begin
            sel_d  = IDX_W'(DEFAULT_STEP);
            fail_d = 1'b1;
          end else begin
            sel_d  = window_mid(win_start_s, win_len_s);
            fail_d = 1'b0;
          end
          load_idx_s = sel_d;
        end
      end
      DONE: begin
`ifdef PLL_CALIB_RELOCK_EN
        if (lock_s) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_W'(LOSS_CYCLES - 1)) begin
          state_d    = APPLY;
          cnt_d      = '0;
          idx_d      = '0;
          lockmap_d  = '0;
          fail_d     = 1'b0;
          load_s     = 1'b1;
          load_idx_s = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`else
        state_d = DONE;
`endif
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    entry_s = entry_at(load_idx_s);
    if (load_s) begin
      icp_d = entry_s.icp;
      lpf_d = entry_s.lpf;
    end else begin
      icp_d = icp_q;
      lpf_d = lpf_q;
    end

    o_rst_d  = (state_d == IDLE) || (state_d == APPLY) || (state_d == FAPPLY);
    o_busy_d = (state_d != DONE);
    o_lock_d = (state_d == DONE) && lock_s;
  end

  // All state and outputs registered; reset is synchronous active-low.
  always_ff @(posedge CLKIN) begin
    if (!I_RSTN) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      sync_q    <= 2'b00;
      lockmap_q <= '0;
      sel_q     <= '0;
      fail_q    <= 1'b0;
      icp_q     <= '0;
      lpf_q     <= '0;
      o_rst_q   <= 1'b1;
      o_lock_q  <= 1'b0;
      o_busy_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      sync_q    <= sync_d;
      lockmap_q <= lockmap_d;
      sel_q     <= sel_d;
      fail_q    <= fail_d;
      icp_q     <= icp_d;
      lpf_q     <= lpf_d;
      o_rst_q   <= o_rst_d;
      o_lock_q  <= o_lock_d;
      o_busy_q  <= o_busy_d;
    end
  end

  assign O_RST     = o_rst_q;
  assign ICPSEL    = icp_q;
  assign LPFRES    = lpf_q;
  assign O_LOCK    = o_lock_q;
  assign O_BUSY    = o_busy_q;
  assign O_FAIL    = fail_q;
  assign O_LOCKMAP = lockmap_q;
  assign O_SEL     = sel_q;

endmodule

// File: tb/tb_pll_calib_seq.sv
// tb_pll_calib_seq: directed checks of the calibration sweep, window selection, dropouts and reset abort.
`timescale 1ns/1ps
module tb_pll_calib_seq;

  function automatic logic [71:0] mk_table();
    logic [71:0] t;
    t = '0;
    for (int i = 0; i < 8; i++) t[i*9 +: 9] = {3'(7 - i), 6'(i + 1)};
    return t;
  endfunction

  localparam logic [71:0] TABLE = mk_table();

  logic       clk;
  logic       i_rstn;
  logic       pll_lock;
  logic       o_rst;
  logic [5:0] icpsel;
  logic [2:0] lpfres;
  logic       o_lock;
  logic       o_busy;
  logic       o_fail;
  logic [7:0] lockmap;
  logic [3:0] o_sel;

  logic [7:0] pattern;
  logic       drop;
  int         tests;
  int         fails;

  pll_calib_seq #(
    .CLK_PERIOD   (10),
    .WAIT_TIME    (100),
    .RST_CYCLES   (4),
    .STEPS        (8),
    .STEP_TABLE   (TABLE),
    .DEFAULT_STEP (5),
    .LOSS_CYCLES  (16)
  ) dut (
    .CLKIN     (clk),
    .I_RSTN    (i_rstn),
    .PLLLOCK   (pll_lock),
    .O_RST     (o_rst),
    .ICPSEL    (icpsel),
    .LPFRES    (lpfres),
    .O_LOCK    (o_lock),
    .O_BUSY    (o_busy),
    .O_FAIL    (o_fail),
    .O_LOCKMAP (lockmap),
    .O_SEL     (o_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PLL model: locks only out of reset, on table entries whose pattern bit is set (entry i has ICPSEL=i+1).
  always_comb begin
    pll_lock = 1'b0;
    if (!o_rst && !drop && icpsel >= 6'd1 && icpsel <= 6'd8) pll_lock = pattern[3'(icpsel - 6'd1)];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (o_busy !== 1'b0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, 32'(o_busy), 32'd0);
  endtask

  task automatic start_sweep(input logic [7:0] pat);
    pattern = pat;
    i_rstn  = 1'b0;
    repeat (3) @(negedge clk);
    i_rstn = 1'b1;
  endtask

  logic [7:0] ex_pat [3];
  logic [3:0] ex_sel [3];

  initial begin
    int n;
    tests   = 0;
    fails   = 0;
    i_rstn  = 1'b0;
    drop    = 1'b0;
    pattern = 8'h3C;
    ex_pat  = '{8'h01, 8'h80, 8'hE3};
    ex_sel  = '{4'd0, 4'd7, 4'd6};

    repeat (3) @(negedge clk);
    check("rst_o_rst",   32'(o_rst),   32'd1);
    check("rst_icpsel",  32'(icpsel),  32'd0);
    check("rst_lpfres",  32'(lpfres),  32'd0);
    check("rst_o_lock",  32'(o_lock),  32'd0);
    check("rst_o_busy",  32'(o_busy),  32'd1);
    check("rst_o_fail",  32'(o_fail),  32'd0);
    check("rst_lockmap", 32'(lockmap), 32'd0);
    check("rst_o_sel",   32'(o_sel),   32'd0);

    // First step: entry 0 applied with a 4-cycle PLL reset pulse.
    i_rstn = 1'b1;
    @(negedge clk);
    check("apply0_rst",    32'(o_rst),  32'd1);
    check("apply0_icpsel", 32'(icpsel), 32'd1);
    check("apply0_lpfres", 32'(lpfres), 32'd7);
    check("apply0_busy",   32'(o_busy), 32'd1);
    repeat (3) @(negedge clk);
    check("apply0_rst_last", 32'(o_rst), 32'd1);
    @(negedge clk);
    check("wait0_rst",    32'(o_rst),  32'd0);
    check("wait0_icpsel", 32'(icpsel), 32'd1);

    wait_done("sweep_3c");
    check("sweep_3c_lockmap", 32'(lockmap), 32'h3C);
    check("sweep_3c_sel",     32'(o_sel),   32'd3);
    check("sweep_3c_fail",    32'(o_fail),  32'd0);
    check("sweep_3c_icpsel",  32'(icpsel),  32'd4);
    check("sweep_3c_lpfres",  32'(lpfres),  32'd4);
    check("sweep_3c_rst",     32'(o_rst),   32'd0);
    repeat (2) @(negedge clk);
    check("sweep_3c_lock",    32'(o_lock),  32'd1);

`ifdef PLL_CALIB_RELOCK_EN
    drop = 1'b1;
    repeat (10) @(negedge clk);
    drop = 1'b0;
    repeat (4) @(negedge clk);
    check("short_drop_busy", 32'(o_busy), 32'd0);
    check("short_drop_lock", 32'(o_lock), 32'd1);
    drop = 1'b1;
    repeat (20) @(negedge clk);
    check("long_drop_busy",    32'(o_busy),  32'd1);
    check("long_drop_icpsel",  32'(icpsel),  32'd1);
    check("long_drop_lockmap", 32'(lockmap), 32'd0);
    check("long_drop_lock",    32'(o_lock),  32'd0);
    drop = 1'b0;
    wait_done("relock");
    check("relock_lockmap", 32'(lockmap), 32'h3C);
    check("relock_sel",     32'(o_sel),   32'd3);
`else
    drop = 1'b1;
    repeat (4) @(negedge clk);
    check("drop_lock_low", 32'(o_lock), 32'd0);
    check("drop_busy",     32'(o_busy), 32'd0);
    repeat (16) @(negedge clk);
    check("drop_lock_low_end", 32'(o_lock), 32'd0);
    check("drop_busy_end",     32'(o_busy), 32'd0);
    drop = 1'b0;
    repeat (4) @(negedge clk);
    check("drop_lock_back", 32'(o_lock), 32'd1);
    check("drop_busy_back", 32'(o_busy), 32'd0);
    check("drop_icpsel",    32'(icpsel), 32'd4);
`endif

    // Reset pulse in the step-4 settle wait aborts the sweep.
    start_sweep(8'h3C);
    n = 0;
    while (!(icpsel == 6'd5 && o_rst == 1'b0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("reach_step4_wait", 32'(icpsel == 6'd5 && o_rst == 1'b0), 32'd1);
    repeat (3) @(negedge clk);
    check("mid_lockmap", 32'(lockmap), 32'h0C);
    i_rstn = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_o_rst",   32'(o_rst),   32'd1);
    check("abort_icpsel",  32'(icpsel),  32'd0);
    check("abort_lpfres",  32'(lpfres),  32'd0);
    check("abort_busy",    32'(o_busy),  32'd1);
    check("abort_lockmap", 32'(lockmap), 32'd0);
    check("abort_sel",     32'(o_sel),   32'd0);
    check("abort_lock",    32'(o_lock),  32'd0);
    i_rstn = 1'b1;
    @(negedge clk);
    check("restart_icpsel", 32'(icpsel), 32'd1);
    wait_done("restart");
    check("restart_lockmap", 32'(lockmap), 32'h3C);
    check("restart_sel",     32'(o_sel),   32'd3);

    // No step locks: default entry 5 applied and failure flagged.
    start_sweep(8'h00);
    wait_done("nolock");
    check("nolock_lockmap", 32'(lockmap), 32'd0);
    check("nolock_sel",     32'(o_sel),   32'd5);
    check("nolock_fail",    32'(o_fail),  32'd1);
    check("nolock_icpsel",  32'(icpsel),  32'd6);
    check("nolock_lpfres",  32'(lpfres),  32'd2);
    repeat (2) @(negedge clk);
    check("nolock_lock",    32'(o_lock),  32'd0);

    // Two equal windows {3,4} and {6,7}: the lower one wins.
    start_sweep(8'hD8);
    wait_done("tie");
    check("tie_lockmap", 32'(lockmap), 32'hD8);
    check("tie_sel",     32'(o_sel),   32'd3);
    check("tie_fail",    32'(o_fail),  32'd0);

    start_sweep(8'hFF);
    wait_done("all");
    check("all_lockmap", 32'(lockmap), 32'hFF);
    check("all_sel",     32'(o_sel),   32'd3);
    check("all_icpsel",  32'(icpsel),  32'd4);

    for (int k = 0; k < 3; k++) begin
      start_sweep(ex_pat[k]);
      wait_done($sformatf("edge%0d", k));
      check($sformatf("edge%0d_lockmap", k), 32'(lockmap), 32'(ex_pat[k]));
      check($sformatf("edge%0d_sel", k),     32'(o_sel),   32'(ex_sel[k]));
      check($sformatf("edge%0d_icpsel", k),  32'(icpsel),  32'(ex_sel[k]) + 32'd1);
      check($sformatf("edge%0d_fail", k),    32'(o_fail),  32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
